axi_slave_ram: RTL and testbench

AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

---
 rtl/axi_slave_ram_if.sv | 40 ++++
 rtl/axi_slave_ram.sv | 138 +++++++++++++
 tb/tb_axi_slave_ram.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_ram_if.sv
// axi_slave_ram_if: AXI4 write/read channel bundle between a burst master and the RAM slave
// Parameter: AXI_WIDTH data width in bits (strobe width AXI_WIDTH/8)
// Modports: slave (RAM side), master (initiator side)
interface axi_slave_ram_if #(
   parameter int AXI_WIDTH = 64
);
   logic [29:0]            s_axi_awaddr;
   logic [7:0]             s_axi_awlen;
   logic                   s_axi_awvalid;
   logic                   s_axi_awready;
   logic [AXI_WIDTH-1:0]   s_axi_wdata;
   logic [AXI_WIDTH/8-1:0] s_axi_wstrb;
   logic                   s_axi_wlast;
   logic                   s_axi_wvalid;
   logic                   s_axi_wready;
   logic [1:0]             s_axi_bresp;
   logic                   s_axi_bvalid;
   logic                   s_axi_bready;
   logic [29:0]            s_axi_araddr;
   logic [7:0]             s_axi_arlen;
   logic                   s_axi_arvalid;
   logic                   s_axi_arready;
   logic [AXI_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]             s_axi_rresp;
   logic                   s_axi_rlast;
   logic                   s_axi_rvalid;
   logic                   s_axi_rready;
   modport slave (
      input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
             s_axi_wvalid, s_axi_bready, s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready, s_axi_rdata,
             s_axi_rresp, s_axi_rlast, s_axi_rvalid
   );
   modport master (
      output s_axi_awaddr, s_axi_awlen, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
             s_axi_wvalid, s_axi_bready, s_axi_araddr, s_axi_arlen, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid, s_axi_arready, s_axi_rdata,
             s_axi_rresp, s_axi_rlast, s_axi_rvalid
   );
endinterface

// File: rtl/axi_slave_ram.sv
// axi_slave_ram: AXI4 INCR-burst slave memory, full-width beats, independent read and write engines
// Ports: clk bus clock, rst_n async active-low reset, s_axi slave modport of axi_slave_ram_if
// Parameters: AXI_WIDTH data width (power of two >= 16), MEM_DEPTH words (power of two)
module axi_slave_ram #(
   parameter int AXI_WIDTH = 64,
   parameter int MEM_DEPTH = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   axi_slave_ram_if.slave   s_axi
);
   localparam int WS = AXI_WIDTH / 8;
   localparam int BW = $clog2(WS);
   localparam int IW = $clog2(MEM_DEPTH);
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;
   w_state_e             w_state_q;
   r_state_e             r_state_q;
   logic [AXI_WIDTH-1:0] mem [MEM_DEPTH];
   logic [IW-1:0]        widx_q, ridx_q;
   logic [7:0]           wlen_q, wcnt_q, rlen_q, rcnt_q;
   logic                 awready_q, wready_q, bvalid_q, err_q;
   logic [1:0]           bresp_q;
   logic                 arready_q, rvalid_q, rlast_q;
   logic [AXI_WIDTH-1:0] rdata_q;
   logic                 w_fire, w_last_beat, w_bad;
   logic [IW-1:0]        aw_idx, ar_idx;
   logic                 unused_addr_bits;
   assign aw_idx      = s_axi.s_axi_awaddr[BW +: IW];
   assign ar_idx      = s_axi.s_axi_araddr[BW +: IW];
   assign w_fire      = s_axi.s_axi_wvalid & wready_q;
   assign w_last_beat = wcnt_q == wlen_q;
   // wlast must coincide exactly with the counted last beat
   assign w_bad       = s_axi.s_axi_wlast != w_last_beat;
   // address bits outside the word index are ignored (sub-word offset and aliasing above depth)
   assign unused_addr_bits = ^{s_axi.s_axi_awaddr[29:BW+IW], s_axi.s_axi_awaddr[BW-1:0],
                               s_axi.s_axi_araddr[29:BW+IW], s_axi.s_axi_araddr[BW-1:0]};
   assign s_axi.s_axi_awready = awready_q;
   assign s_axi.s_axi_wready  = wready_q;
   assign s_axi.s_axi_bvalid  = bvalid_q;
   assign s_axi.s_axi_bresp   = bresp_q;
   assign s_axi.s_axi_arready = arready_q;
   assign s_axi.s_axi_rvalid  = rvalid_q;
   assign s_axi.s_axi_rlast   = rlast_q;
   assign s_axi.s_axi_rdata   = rdata_q;
   assign s_axi.s_axi_rresp   = 2'b00;
   always_ff @(posedge clk)
      if (w_fire)
         for (int i = 0; i < WS; i++)
            if (s_axi.s_axi_wstrb[i]) mem[widx_q][8*i +: 8] <= s_axi.s_axi_wdata[8*i +: 8];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         err_q     <= 1'b0;
         widx_q    <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (awready_q && s_axi.s_axi_awvalid) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  widx_q    <= aw_idx;
                  wlen_q    <= s_axi.s_axi_awlen;
                  wcnt_q    <= '0;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  widx_q <= widx_q + IW'(1);
                  wcnt_q <= wcnt_q + 8'd1;
                  err_q  <= err_q | w_bad;
                  if (w_last_beat) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bresp_q   <= (err_q | w_bad) ? 2'b10 : 2'b00;
                     w_state_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (s_axi.s_axi_bready) begin
                  bvalid_q  <= 1'b0;
                  bresp_q   <= 2'b00;
                  err_q     <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end
   // rdata is loaded with a nonblocking read, so a same-edge write to that word is not yet visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= '0;
         ridx_q    <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
      end else if (r_state_q == R_IDLE) begin
         arready_q <= 1'b1;
         if (arready_q && s_axi.s_axi_arvalid) begin
            arready_q <= 1'b0;
            rdata_q   <= mem[ar_idx];
            ridx_q    <= ar_idx + IW'(1);
            rlen_q    <= s_axi.s_axi_arlen;
            rcnt_q    <= '0;
            rlast_q   <= s_axi.s_axi_arlen == 8'd0;
            rvalid_q  <= 1'b1;
            r_state_q <= R_DATA;
         end
      end else if (s_axi.s_axi_rready) begin
         if (rlast_q) begin
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
         end else begin
            rdata_q <= mem[ridx_q];
            ridx_q  <= ridx_q + IW'(1);
            rcnt_q  <= rcnt_q + 8'd1;
            rlast_q <= (rcnt_q + 8'd1) == rlen_q;
         end
      end
   end
endmodule

// File: tb/tb_axi_slave_ram.sv
// tb_axi_slave_ram: randomized self-checking bench for axi_slave_ram against a word-array memory model
// Drives the master modport on falling edges and samples DUT outputs on falling edges.
module tb_axi_slave_ram;
   localparam int DEP = 1024;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errs = 0;
   int   checks = 0;
   logic [63:0] ref_mem [DEP];
   logic [63:0] wd [256];
   logic [7:0]  ws [256];
   bit          wl [256];
   axi_slave_ram_if #(.AXI_WIDTH(64)) axi ();
   axi_slave_ram #(.AXI_WIDTH(64), .MEM_DEPTH(DEP)) dut (.clk(clk), .rst_n(rst_n), .s_axi(axi.slave));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic int word_of(input logic [29:0] a);
      return int'(a / 8) % DEP;
   endfunction
   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] s);
      logic [63:0] m = '0;
      for (int k = 0; k < 8; k++) if (s[k]) m |= 64'hFF << (8 * k);
      return (old & ~m) | (d & m);
   endfunction
   task automatic fill(input int len);
      for (int b = 0; b < 256; b++) begin
         wd[b] = {$urandom, $urandom};
         ws[b] = 8'hFF;
         wl[b] = (b == len);
      end
   endtask
   task automatic chk_reset_outputs();
      chk("rst_awready", axi.s_axi_awready, 0);
      chk("rst_wready", axi.s_axi_wready, 0);
      chk("rst_bvalid", axi.s_axi_bvalid, 0);
      chk("rst_bresp", axi.s_axi_bresp, 0);
      chk("rst_arready", axi.s_axi_arready, 0);
      chk("rst_rvalid", axi.s_axi_rvalid, 0);
      chk("rst_rlast", axi.s_axi_rlast, 0);
      chk("rst_rresp", axi.s_axi_rresp, 0);
      chk("rst_rdata", axi.s_axi_rdata, 0);
   endtask
   task automatic write_burst(input logic [29:0] a, input logic [7:0] l, input bit gaps);
      int i = word_of(a);
      bit bad = 0;
      int t;
      @(negedge clk);
      axi.s_axi_awaddr = a;
      axi.s_axi_awlen = l;
      axi.s_axi_awvalid = 1;
      t = 0;
      while (!axi.s_axi_awready && t < 100) begin @(negedge clk); t++; end
      chk("awready", axi.s_axi_awready, 1);
      @(negedge clk);
      axi.s_axi_awvalid = 0;
      for (int b = 0; b <= int'(l); b++) begin
         if (gaps && $urandom_range(3) == 0) begin
            axi.s_axi_wvalid = 0;
            @(negedge clk);
         end
         axi.s_axi_wdata = wd[b];
         axi.s_axi_wstrb = ws[b];
         axi.s_axi_wlast = wl[b];
         axi.s_axi_wvalid = 1;
         t = 0;
         while (!axi.s_axi_wready && t < 100) begin @(negedge clk); t++; end
         chk("wready", axi.s_axi_wready, 1);
         ref_mem[i] = merge(ref_mem[i], wd[b], ws[b]);
         bad |= wl[b] != (b == int'(l));
         i = (i + 1) % DEP;
         @(negedge clk);
      end
      axi.s_axi_wvalid = 0;
      axi.s_axi_wlast = 0;
      t = 0;
      while (!axi.s_axi_bvalid && t < 100) begin @(negedge clk); t++; end
      chk("bvalid", axi.s_axi_bvalid, 1);
      chk("bresp", axi.s_axi_bresp, bad ? 64'd2 : 64'd0);
      chk("wready_in_resp", axi.s_axi_wready, 0);
      repeat ($urandom_range(2)) @(negedge clk);
      axi.s_axi_bready = 1;
      @(negedge clk);
      axi.s_axi_bready = 0;
      chk("bvalid_clear", axi.s_axi_bvalid, 0);
   endtask
   // mode 0: rready always high, 1: 1010... starting high, 2: random
   task automatic read_burst(input logic [29:0] a, input logic [7:0] l, input int mode);
      int i = word_of(a);
      int b = 0;
      int t;
      bit rr;
      bit ph = 1;
      @(negedge clk);
      axi.s_axi_araddr = a;
      axi.s_axi_arlen = l;
      axi.s_axi_arvalid = 1;
      t = 0;
      while (!axi.s_axi_arready && t < 100) begin @(negedge clk); t++; end
      chk("arready", axi.s_axi_arready, 1);
      @(negedge clk);
      axi.s_axi_arvalid = 0;
      chk("first_beat_latency", axi.s_axi_rvalid, 1);
      t = 0;
      while (b <= int'(l) && t < 2000) begin
         chk("rvalid", axi.s_axi_rvalid, 1);
         chk("rdata", axi.s_axi_rdata, ref_mem[i]);
         chk("rlast", axi.s_axi_rlast, b == int'(l));
         rr = mode == 0 ? 1'b1 : mode == 1 ? ph : 1'($urandom_range(1));
         ph = !ph;
         axi.s_axi_rready = rr;
         @(negedge clk);
         if (rr) begin
            b++;
            i = (i + 1) % DEP;
         end
         t++;
      end
      axi.s_axi_rready = 0;
      chk("read_done", axi.s_axi_rvalid, 0);
   endtask
   initial begin
      axi.s_axi_awaddr = '0;
      axi.s_axi_awlen = '0;
      axi.s_axi_awvalid = 0;
      axi.s_axi_wdata = '0;
      axi.s_axi_wstrb = '0;
      axi.s_axi_wlast = 0;
      axi.s_axi_wvalid = 0;
      axi.s_axi_bready = 0;
      axi.s_axi_araddr = '0;
      axi.s_axi_arlen = '0;
      axi.s_axi_arvalid = 0;
      axi.s_axi_rready = 0;
      for (int k = 0; k < DEP; k++) ref_mem[k] = '0;
      repeat (2) @(negedge clk);
      chk_reset_outputs();
      rst_n = 1;
      @(negedge clk);
      chk("awready_after_reset", axi.s_axi_awready, 1);
      chk("arready_after_reset", axi.s_axi_arready, 1);
      // give every word a known value with four 256-beat bursts
      for (int k = 0; k < 4; k++) begin
         fill(255);
         write_burst(30'(k * 2048), 8'd255, 0);
      end
      fill(3);
      for (int b = 0; b < 4; b++) wd[b] = 64'h11 * (b + 1);
      write_burst(30'h0, 8'd3, 0);
      read_burst(30'h0, 8'd3, 0);
      chk("dir_word2", ref_mem[2], 64'h33);
      fill(0);
      wd[0] = '1;
      write_burst(30'd40, 8'd0, 0);
      wd[0] = '0;
      ws[0] = 8'h0F;
      write_burst(30'd40, 8'd0, 0);
      read_burst(30'd40, 8'd0, 0);
      chk("strobe_merge", ref_mem[5], 64'hFFFF_FFFF_0000_0000);
      fill(1);
      wl[0] = 1;
      wl[1] = 0;
      write_burst(30'h80, 8'd1, 0);
      read_burst(30'h80, 8'd1, 0);
      fill(1);
      write_burst(30'h80, 8'd1, 1);
      read_burst(30'h80, 8'd1, 2);
      fill(1);
      write_burst(30'(1023 * 8), 8'd1, 0);
      read_burst(30'(1023 * 8), 8'd1, 0);
      read_burst(30'h0, 8'd0, 0);
      read_burst(30'h300, 8'd7, 1);
      repeat (25) begin
         fill($urandom_range(15));
         for (int b = 0; b < 256; b++) ws[b] = 8'($urandom);
         write_burst(30'($urandom), 8'($urandom_range(15)), 1);
         for (int b = 0; b < 256; b++) if (wl[b] && $urandom_range(5) == 0) wl[b] = 0;
         read_burst(30'($urandom), 8'($urandom_range(15)), 2);
      end
      fill(15);
      fork
         write_burst(30'h0, 8'd15, 1);
         read_burst(30'(512 * 8), 8'd15, 2);
      join
      read_burst(30'h0, 8'd15, 2);
      // reset in the middle of a write burst and a read burst
      @(negedge clk);
      axi.s_axi_awaddr = 30'h100;
      axi.s_axi_awlen = 8'd7;
      axi.s_axi_awvalid = 1;
      axi.s_axi_araddr = 30'h200;
      axi.s_axi_arlen = 8'd7;
      axi.s_axi_arvalid = 1;
      chk("mid_awready", axi.s_axi_awready, 1);
      chk("mid_arready", axi.s_axi_arready, 1);
      @(negedge clk);
      axi.s_axi_awvalid = 0;
      axi.s_axi_arvalid = 0;
      for (int b = 0; b < 2; b++) begin
         axi.s_axi_wdata = {$urandom, $urandom};
         axi.s_axi_wstrb = 8'hFF;
         axi.s_axi_wlast = 0;
         axi.s_axi_wvalid = 1;
         chk("mid_wready", axi.s_axi_wready, 1);
         ref_mem[32 + b] = axi.s_axi_wdata;
         @(negedge clk);
      end
      axi.s_axi_wvalid = 0;
      chk("mid_rvalid", axi.s_axi_rvalid, 1);
      #2 rst_n = 0;
      #1 chk_reset_outputs();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("awready_after_rerelease", axi.s_axi_awready, 1);
      chk("arready_after_rerelease", axi.s_axi_arready, 1);
      read_burst(30'h100, 8'd7, 2);
      fill(5);
      write_burst(30'h200, 8'd5, 1);
      read_burst(30'h200, 8'd5, 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
